// File: rtl/arb21_rr.sv
// arb21_rr: two-requester round-robin arbiter for a shared 2:1 data mux.
// Grants the channel to one source at a time, drives the mux select,
// registers the selected beat onto Y and caps each grant at MAXBURST beats.
module arb21_rr #(
    parameter int W        = 8,
    parameter int MAXBURST = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         REQ0,
    input  logic         REQ1,
    input  logic [W-1:0] D0,
    input  logic [W-1:0] D1,
    output logic         GNT0,
    output logic         GNT1,
    output logic         SEL,
    output logic [W-1:0] Y,
    output logic         VALID
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    // Beat count at which the current burst ends.
    localparam logic [7:0] LAST_BEAT = 8'(MAXBURST - 1);

    state_t         state_q, state_d;
    logic   [7:0]   cnt_q,   cnt_d;
    logic           ptr_q,   ptr_d;
    logic           sel_q,   sel_d;
    logic   [W-1:0] y_q,     y_d;
    logic           valid_q, valid_d;

    // Next-state, burst counting and data capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        y_d     = y_q;
        valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (REQ0 && REQ1) begin
                    // Contention: serve the source that was not served last.
                    state_d = ptr_q ? G0 : G1;
                end else if (REQ0) begin
                    state_d = G0;
                end else if (REQ1) begin
                    state_d = G1;
                end
            end
            G0: begin
                if (REQ0) begin
                    y_d     = D0;
                    valid_d = 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        // Burst end: hand over if the other side waits,
                        // otherwise start a fresh burst without a gap.
                        ptr_d   = 1'b0;
                        cnt_d   = 8'd0;
                        state_d = REQ1 ? G1 : G0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else begin
                    ptr_d   = 1'b0;
                    cnt_d   = 8'd0;
                    state_d = REQ1 ? G1 : IDLE;
                end
            end
            G1: begin
                if (REQ1) begin
                    y_d     = D1;
                    valid_d = 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        ptr_d   = 1'b1;
                        cnt_d   = 8'd0;
                        state_d = REQ0 ? G0 : G1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else begin
                    ptr_d   = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = REQ0 ? G0 : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Select follows the granted source on the same edge; IDLE keeps it.
        if (state_d == G0) begin
            sel_d = 1'b0;
        end else if (state_d == G1) begin
            sel_d = 1'b1;
        end
    end

    // State and output registers; reset wins over any transition or beat.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            ptr_q   <= 1'b1;
            sel_q   <= 1'b0;
            y_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            y_q     <= y_d;
            valid_q <= valid_d;
        end
    end

    assign GNT0  = (state_q == G0);
    assign GNT1  = (state_q == G1);
    assign SEL   = sel_q;
    assign Y     = y_q;
    assign VALID = valid_q;

endmodule

// File: tb/tb_arb21_rr.sv
// tb_arb21_rr: directed scoreboard bench for arb21_rr (W=8, MAXBURST=4).
module tb_arb21_rr;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       REQ0 = 1'b0;
    logic       REQ1 = 1'b0;
    logic [7:0] D0 = 8'h00;
    logic [7:0] D1 = 8'h00;
    logic       GNT0, GNT1, SEL, VALID;
    logic [7:0] Y;

    int         checks   = 0;
    int         failures = 0;
    int         cidx     = 0;
    string      tn       = "init";
    logic [7:0] exp_q[$];

    arb21_rr #(.W(8), .MAXBURST(4)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .REQ0  (REQ0),
        .REQ1  (REQ1),
        .D0    (D0),
        .D1    (D1),
        .GNT0  (GNT0),
        .GNT1  (GNT1),
        .SEL   (SEL),
        .Y     (Y),
        .VALID (VALID)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Apply one cycle of inputs; after the edge check grant/select/valid.
    // When a beat is expected, its data goes to the scoreboard first.
    task automatic cyc(input logic rst, input logic r0, input logic r1,
                       input logic [7:0] d0, input logic [7:0] d1,
                       input logic ev, input logic [7:0] ey,
                       input logic eg0, input logic eg1, input logic es);
        RST  = rst;
        REQ0 = r0;
        REQ1 = r1;
        D0   = d0;
        D1   = d1;
        if (ev) exp_q.push_back(ey);
        @(posedge CLK);
        #1;
        chk($sformatf("%s c%0d VALID", tn, cidx), {31'd0, VALID}, {31'd0, ev});
        chk($sformatf("%s c%0d GNT0", tn, cidx), {31'd0, GNT0}, {31'd0, eg0});
        chk($sformatf("%s c%0d GNT1", tn, cidx), {31'd0, GNT1}, {31'd0, eg1});
        chk($sformatf("%s c%0d SEL", tn, cidx), {31'd0, SEL}, {31'd0, es});
        if (rst) chk($sformatf("%s c%0d Y after reset", tn, cidx), {24'd0, Y}, 32'd0);
        cidx++;
    endtask

    task automatic do_reset(input string name);
        tn   = name;
        cidx = 0;
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        RST = 1'b0;
    endtask

    // Monitor: every presented beat must match the oldest expected value.
    always @(negedge CLK) begin
        chk("grant mutex", {31'd0, GNT0 & GNT1}, 32'd0);
        if (VALID !== 1'b0) begin
            if (VALID !== 1'b1) begin
                chk("VALID known", {31'd0, VALID}, 32'd0);
            end else if (exp_q.size() == 0) begin
                chk("unexpected beat Y", {24'd0, Y}, 32'hFFFF_FFFF);
            end else begin
                chk($sformatf("%s beat Y", tn), {24'd0, Y}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        // Reset then single requester
        do_reset("reset");
        do_reset("single");
        cyc(0, 1, 0, 8'h11, 8'h00, 0, 8'h00, 1, 0, 0);
        cyc(0, 1, 0, 8'h11, 8'h00, 1, 8'h11, 1, 0, 0);
        cyc(0, 1, 0, 8'h22, 8'h00, 1, 8'h22, 1, 0, 0);
        cyc(0, 1, 0, 8'h33, 8'h00, 1, 8'h33, 1, 0, 0);
        cyc(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0);
        cyc(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0);

        // Continuous contention: 4 beats each, alternating, no bubble
        do_reset("contend");
        cyc(0, 1, 1, 8'hA0, 8'hB0, 0, 8'h00, 1, 0, 0);
        cyc(0, 1, 1, 8'hA0, 8'hB0, 1, 8'hA0, 1, 0, 0);
        cyc(0, 1, 1, 8'hA1, 8'hB0, 1, 8'hA1, 1, 0, 0);
        cyc(0, 1, 1, 8'hA2, 8'hB0, 1, 8'hA2, 1, 0, 0);
        cyc(0, 1, 1, 8'hA3, 8'hB0, 1, 8'hA3, 0, 1, 1);
        cyc(0, 1, 1, 8'hA4, 8'hB0, 1, 8'hB0, 0, 1, 1);
        cyc(0, 1, 1, 8'hA4, 8'hB1, 1, 8'hB1, 0, 1, 1);
        cyc(0, 1, 1, 8'hA4, 8'hB2, 1, 8'hB2, 0, 1, 1);
        cyc(0, 1, 1, 8'hA4, 8'hB3, 1, 8'hB3, 1, 0, 0);
        cyc(0, 1, 1, 8'hA4, 8'hB4, 1, 8'hA4, 1, 0, 0);
        cyc(0, 1, 1, 8'hA5, 8'hB4, 1, 8'hA5, 1, 0, 0);
        cyc(0, 1, 1, 8'hA6, 8'hB4, 1, 8'hA6, 1, 0, 0);
        cyc(0, 1, 1, 8'hA7, 8'hB4, 1, 8'hA7, 0, 1, 1);
        cyc(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 1);

        // Early drop: two beats from source 0, one dead cycle, then G1
        do_reset("drop");
        cyc(0, 1, 0, 8'hC0, 8'h00, 0, 8'h00, 1, 0, 0);
        cyc(0, 1, 1, 8'hC0, 8'hD0, 1, 8'hC0, 1, 0, 0);
        cyc(0, 1, 1, 8'hC1, 8'hD0, 1, 8'hC1, 1, 0, 0);
        cyc(0, 0, 1, 8'hC2, 8'hD0, 0, 8'h00, 0, 1, 1);
        cyc(0, 0, 1, 8'h00, 8'hD0, 1, 8'hD0, 0, 1, 1);
        cyc(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 1);

        // Solo requester re-granted at each burst end without a gap
        do_reset("solo");
        cyc(0, 0, 1, 8'h00, 8'h50, 0, 8'h00, 0, 1, 1);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 1, 8'h00, 8'(8'h50 + i), 1, 8'(8'h50 + i), 0, 1, 1);
        end
        cyc(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 1);
        // Last served was source 1, so contention now goes to source 0
        cyc(0, 1, 1, 8'h00, 8'h00, 0, 8'h00, 1, 0, 0);
        cyc(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0);

        // Reset during the third beat of a G1 burst
        do_reset("midrst");
        cyc(0, 0, 1, 8'h00, 8'hE0, 0, 8'h00, 0, 1, 1);
        cyc(0, 0, 1, 8'h00, 8'hE0, 1, 8'hE0, 0, 1, 1);
        cyc(0, 0, 1, 8'h00, 8'hE1, 1, 8'hE1, 0, 1, 1);
        cyc(1, 0, 1, 8'h00, 8'hE2, 0, 8'h00, 0, 0, 0);
        cyc(0, 1, 1, 8'hF0, 8'hE3, 0, 8'h00, 1, 0, 0);
        cyc(0, 1, 1, 8'hF0, 8'hE3, 1, 8'hF0, 1, 0, 0);
        cyc(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0);

        @(posedge CLK);
        #1;
        chk("scoreboard drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
